ysyx_25020047_ifu: RTL

//  Multi-cycle instruction fetch unit. It is the consumer of the next-PC (dnpc) that writeback produces.
//  - Fetches the word at pc over a valid/ready read channel.
//  - Hands {inst, pc, snpc} to decode.
//  - Then waits for writeback to return dnpc before the next fetch. The core is non-pipelined: one instruction in flight.

---
 rtl/ysyx_25020047_ifu_pkg.sv | 32 +++
 rtl/ysyx_25020047_ifu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: the FSM state encoding,
// the fault cause codes, the OKAY bus response and an alignment helper.
package ysyx_25020047_ifu_pkg;

    // One instruction in flight: request, response, hand-off, wait for dnpc.
    // ST_ERR is terminal until reset.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_RESP   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAITWB = 3'd3,
        ST_ERR    = 3'd4
    } ifu_state_e;

    // Values reported on err_cause.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BUS      = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;

    // Read response code for a successful access.
    localparam logic [1:0] RESP_OKAY = 2'd0;

    // Distance from an instruction to its sequential successor.
    localparam logic [31:0] INST_BYTES = 32'd4;

    // Instructions are 32-bit words, so a legal fetch address has its two
    // low bits clear.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_25020047_ifu.sv
// Multi-cycle instruction fetch unit for a non-pipelined core.
// Fetches the word at pc, hands {inst, pc, snpc} to decode, then waits for
// writeback to return dnpc before starting the next fetch. Every output is
// either a register or a decode of the state register, so no input reaches
// an output valid combinationally.
module ysyx_25020047_ifu
    import ysyx_25020047_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,

    output logic             mem_arvalid,
    output logic [31:0]      mem_araddr,
    input  logic             mem_arready,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    input  logic [1:0]       mem_rresp,
    output logic             mem_rready,

    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [31:0]      pc,
    output logic [31:0]      snpc,

    input  logic             wb_valid,
    input  logic [31:0]      dnpc,

    output logic             fetch_err,
    output logic [1:0]       err_cause,
    output logic [CNT_W-1:0] fetch_cnt
);

    ifu_state_e       state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      inst_reg, inst_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       cause_reg, cause_next;

    // The reset state is FETCH, but the read request must stay low while
    // reset is held and only rise after release. This flag is cleared by
    // reset and set by the first clock edge after release; it then stays set.
    logic             started_reg;

    // State, architectural registers and the start-up flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            pc_reg      <= RESET_PC;
            inst_reg    <= '0;
            cnt_reg     <= '0;
            cause_reg   <= ERR_NONE;
            started_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            cnt_reg     <= cnt_next;
            cause_reg   <= cause_next;
            started_reg <= 1'b1;
        end
    end

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        cnt_next   = cnt_reg;
        cause_next = cause_reg;

        case (state_reg)
            ST_FETCH: begin
                // The request is only visible once started_reg is set, so
                // only then can it be accepted.
                if (started_reg && mem_arready) begin
                    state_next = ST_RESP;
                end
            end

            ST_RESP: begin
                if (mem_rvalid) begin
                    if (mem_rresp == RESP_OKAY) begin
                        inst_next  = mem_rdata;
                        state_next = ST_ISSUE;
                    end else begin
                        cause_next = ERR_BUS;
                        state_next = ST_ERR;
                    end
                end
            end

            ST_ISSUE: begin
                // inst/pc come straight from registers that only change
                // outside this state, so they stay stable while decode stalls.
                if (inst_ready) begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    state_next = ST_WAITWB;
                end
            end

            ST_WAITWB: begin
                // dnpc is only sampled here; wb_valid in other states is
                // ignored.
                if (wb_valid) begin
                    pc_next = dnpc;
                    if (is_word_aligned(dnpc)) begin
                        state_next = ST_FETCH;
                    end else begin
                        cause_next = ERR_MISALIGN;
                        state_next = ST_ERR;
                    end
                end
            end

            ST_ERR: begin
                state_next = ST_ERR;
            end

            default: begin
                state_next = ST_ERR;
            end
        endcase
    end

    // Handshake outputs decoded from the state register only.
    assign mem_arvalid = (state_reg == ST_FETCH) && started_reg;
    assign mem_rready  = (state_reg == ST_RESP);
    assign inst_valid  = (state_reg == ST_ISSUE);
    assign fetch_err   = (state_reg == ST_ERR);

    // Data outputs straight from registers; snpc wraps naturally at 2^32.
    assign mem_araddr  = pc_reg;
    assign pc          = pc_reg;
    assign snpc        = pc_reg + INST_BYTES;
    assign inst        = inst_reg;
    assign err_cause   = cause_reg;
    assign fetch_cnt   = cnt_reg;

endmodule
